axil_sorter_reader: RTL and testbench
=====================================

AXIL_SORTER_READER -- requirements
Module: axil_sorter_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data width of the val/ival FIFO entries (1..32).
REQ-002 SHALL have parameter DEPTH, default 10, meaning width of the FIFO occupancy counters (1..12).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port ARADDR  input  32  AXI4-Lite read address.
REQ-006 SHALL have ports ARVALID input 1 and ARREADY output 1, the read-address handshake.
REQ-007 SHALL have port RDATA  output  32  read data.
REQ-008 SHALL have port RRESP  output  2  read response (00 OKAY, 10 SLVERR, 11 DECERR).
REQ-009 SHALL have ports RVALID output 1 and RREADY input 1, the read-data handshake.
REQ-010 SHALL have ports val_rd_en and ival_rd_en, output, 1 bit each, meaning single-cycle pop strobes to the val and ival FIFOs.
REQ-011 SHALL have ports val_dout and ival_dout, input, WIDTH bits each, meaning FIFO read data, valid the cycle after the rd_en strobe.
REQ-012 SHALL have ports val_empty, val_full, ival_empty and ival_full, input, 1 bit each, meaning FIFO flags.
REQ-013 SHALL have ports val_fifo_ctr and ival_fifo_ctr, input, DEPTH bits each, meaning FIFO occupancy.

Function
REQ-014 Address map SHALL be a full 32-bit compare: 0x00 pops val, 0x04 pops ival, 0x08 reads status, and all other addresses decode to DECERR.
REQ-015 The FSM SHALL have the states IDLE, FETCH and RESP.
REQ-016 IDLE SHALL drive ARREADY=1; on ARVALID it latches ARADDR.
REQ-017 In IDLE, on ARVALID for a pop address with a non-empty FIFO, the block SHALL pulse the matching rd_en for exactly one cycle and go to FETCH.
REQ-018 FETCH SHALL register the FIFO dout, zero-extended to 32 bits, into RDATA with RRESP=00 and go to RESP with RVALID=1.
REQ-019 In IDLE, on ARVALID for a pop address with an empty FIFO, the block SHALL NOT strobe rd_en, and SHALL go to RESP with RDATA=0 and RRESP=10.
REQ-020 In IDLE, on ARVALID for the status address, the block SHALL go to RESP with RRESP=00 and RDATA = {ival_full, val_full, ival_empty, val_empty} in [31:28], ival_fifo_ctr zero-extended in [27:16], val_fifo_ctr zero-extended in [11:0], and zeros elsewhere, sampled in the accept cycle.
REQ-021 In IDLE, on ARVALID for an unmapped address, the block SHALL go to RESP with RDATA=0 and RRESP=11.
REQ-022 RESP SHALL hold RVALID, RDATA and RRESP stable until RREADY=1, then go to IDLE on the next edge.
REQ-023 ARREADY SHALL be 0 in FETCH and RESP, so only one outstanding read exists at a time.
REQ-024 Latency SHALL be measured from the AR handshake edge (cycle 0): RVALID rises at cycle 2 for a successful pop, and at cycle 1 for status, empty-pop and decode-error reads.
REQ-025 At most one rd_en SHALL be high in any cycle, and each accepted pop SHALL produce exactly one rd_en pulse.
REQ-026 RREADY already high when RVALID rises SHALL complete the transfer in that cycle, giving a sustained throughput of one pop per 3 cycles.
REQ-027 A read while the FIFO is concurrently being written SHALL use the empty flag sampled in the AR accept cycle.

Reset
REQ-028 While rst=1, the block SHALL hold state=IDLE, ARREADY=0, RVALID=0, RDATA=0, RRESP=00, val_rd_en=0 and ival_rd_en=0.
REQ-029 ARREADY SHALL be 1 in the first cycle after rst falls.
REQ-030 Reset asserted during FETCH or RESP SHALL abandon the transaction without issuing a further rd_en, and the in-flight response is lost.

Structure
REQ-031 The shared package axil_sorter_pkg SHALL hold the address constants (ADDR_VAL=0x00, ADDR_IVAL=0x04, ADDR_STAT=0x08), the RESP codes, and the FSM state enum.
REQ-032 The block SHALL be a single module with no sub-module; the FSM and decode are small enough to stay flat.

Verification
REQ-033 Status read with val_fifo_ctr=2, ival_fifo_ctr=1 and val_full=ival_full=0 -> RDATA=0x0001_0002 and RRESP=00 at cycle 1.
REQ-034 Pop of 0x00 with val_dout=0x0000_00A5 on the cycle after the strobe -> val_rd_en high for one cycle only, then RDATA=0x0000_00A5 and RRESP=00 at cycle 2.
REQ-035 Pop of 0x04 with ival_empty=1 -> no ival_rd_en pulse, RDATA=0 and RRESP=10.
REQ-036 Read of 0x0C -> RRESP=11, RDATA=0, and no rd_en pulse.
REQ-037 Pop of 0x00 with RREADY held low for 4 cycles -> RVALID, RDATA and RRESP stay stable, ARREADY=0 throughout, and ARREADY returns to 1 the cycle after RREADY.
REQ-038 rst asserted in RESP -> RVALID=0 on the next edge, and ARREADY=1 one cycle after rst falls.

Source files
------------

// File: rtl/axil_sorter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axil_sorter_pkg
// Brief    : Address map, AXI response codes and FSM states for the sorter
//            FIFO AXI4-Lite read port.
// Revision : 1.0 - initial release
// ============================================================================
package axil_sorter_pkg;

    localparam logic [31:0] ADDR_VAL    = 32'h0000_0000;
    localparam logic [31:0] ADDR_IVAL   = 32'h0000_0004;
    localparam logic [31:0] ADDR_STAT   = 32'h0000_0008;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    // Status word: flags on top, 12-bit occupancy fields for each FIFO.
    function automatic logic [31:0] pack_status(
        input logic        ival_full,
        input logic        val_full,
        input logic        ival_empty,
        input logic        val_empty,
        input logic [11:0] ival_ctr,
        input logic [11:0] val_ctr
    );
        return {ival_full, val_full, ival_empty, val_empty, ival_ctr, 4'h0, val_ctr};
    endfunction

endpackage
`default_nettype wire

// File: rtl/axil_sorter_reader.sv
`default_nettype none
// ============================================================================
// Module   : axil_sorter_reader
// Brief    : AXI4-Lite read-only slave that pops the val/ival FIFOs or
//            returns their status, one outstanding read at a time.
// Revision : 1.0 - initial release
// ============================================================================
module axil_sorter_reader
    import axil_sorter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      ARADDR,
    input  logic             ARVALID,
    output logic             ARREADY,
    output logic [31:0]      RDATA,
    output logic [1:0]       RRESP,
    output logic             RVALID,
    input  logic             RREADY,
    output logic             val_rd_en,
    output logic             ival_rd_en,
    input  logic [WIDTH-1:0] val_dout,
    input  logic [WIDTH-1:0] ival_dout,
    input  logic             val_empty,
    input  logic             val_full,
    input  logic             ival_empty,
    input  logic             ival_full,
    input  logic [DEPTH-1:0] val_fifo_ctr,
    input  logic [DEPTH-1:0] ival_fifo_ctr
);

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_araddr;
    logic [31:0] w_araddr_next;
    logic [31:0] r_rdata;
    logic [31:0] w_rdata_next;
    logic [1:0]  r_rresp;
    logic [1:0]  w_rresp_next;
    logic        r_rvalid;
    logic        w_rvalid_next;
    logic        w_val_pop;
    logic        w_ival_pop;
    logic [11:0] w_val_ctr;
    logic [11:0] w_ival_ctr;

    assign w_val_ctr  = 12'(val_fifo_ctr);
    assign w_ival_ctr = 12'(ival_fifo_ctr);

    always_comb begin
        w_state_next  = r_state;
        w_araddr_next = r_araddr;
        w_rdata_next  = r_rdata;
        w_rresp_next  = r_rresp;
        w_rvalid_next = r_rvalid;
        w_val_pop     = 1'b0;
        w_ival_pop    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (ARVALID) begin
                    // Non-pop outcomes answer directly; a real pop detours via FETCH.
                    w_araddr_next = ARADDR;
                    w_state_next  = ST_RESP;
                    w_rvalid_next = 1'b1;
                    w_rdata_next  = 32'h0;
                    w_rresp_next  = RESP_OKAY;
                    case (ARADDR)
                        ADDR_VAL: begin
                            if (val_empty) begin
                                w_rresp_next = RESP_SLVERR;
                            end else begin
                                w_val_pop     = 1'b1;
                                w_state_next  = ST_FETCH;
                                w_rvalid_next = 1'b0;
                            end
                        end
                        ADDR_IVAL: begin
                            if (ival_empty) begin
                                w_rresp_next = RESP_SLVERR;
                            end else begin
                                w_ival_pop    = 1'b1;
                                w_state_next  = ST_FETCH;
                                w_rvalid_next = 1'b0;
                            end
                        end
                        ADDR_STAT: begin
                            w_rdata_next = pack_status(ival_full, val_full, ival_empty,
                                                       val_empty, w_ival_ctr, w_val_ctr);
                        end
                        default: begin
                            w_rresp_next = RESP_DECERR;
                        end
                    endcase
                end
            end
            ST_FETCH: begin
                // FIFO dout is valid now, one cycle after the pop strobe.
                w_rdata_next  = (r_araddr == ADDR_IVAL) ? 32'(ival_dout) : 32'(val_dout);
                w_rresp_next  = RESP_OKAY;
                w_rvalid_next = 1'b1;
                w_state_next  = ST_RESP;
            end
            ST_RESP: begin
                if (RREADY) begin
                    w_rvalid_next = 1'b0;
                    w_state_next  = ST_IDLE;
                end
            end
            default: begin
                w_state_next  = ST_IDLE;
                w_rvalid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_araddr <= 32'h0;
            r_rdata  <= 32'h0;
            r_rresp  <= RESP_OKAY;
            r_rvalid <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_araddr <= w_araddr_next;
            r_rdata  <= w_rdata_next;
            r_rresp  <= w_rresp_next;
            r_rvalid <= w_rvalid_next;
        end
    end

    // Gate with rst so nothing is accepted or popped while reset is held.
    assign ARREADY    = (r_state == ST_IDLE) && !rst;
    assign val_rd_en  = w_val_pop && !rst;
    assign ival_rd_en = w_ival_pop && !rst;
    assign RDATA      = r_rdata;
    assign RRESP      = r_rresp;
    assign RVALID     = r_rvalid;

endmodule
`default_nettype wire

// File: tb/tb_axil_sorter_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_axil_sorter_reader
// Brief    : Self-checking bench: directed vector table, reset/stall corner
//            sequences and randomized reads against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axil_sorter_reader;

    localparam int WIDTH    = 16;
    localparam int DEPTH    = 10;
    localparam int FULL_LVL = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [31:0]       ARADDR = 32'h0;
    logic              ARVALID = 1'b0;
    logic              ARREADY;
    logic [31:0]       RDATA;
    logic [1:0]        RRESP;
    logic              RVALID;
    logic              RREADY = 1'b1;
    logic              val_rd_en;
    logic              ival_rd_en;
    logic [WIDTH-1:0]  val_dout;
    logic [WIDTH-1:0]  ival_dout;
    logic              val_empty;
    logic              val_full;
    logic              ival_empty;
    logic              ival_full;
    logic [DEPTH-1:0]  val_fifo_ctr;
    logic [DEPTH-1:0]  ival_fifo_ctr;

    int total = 0;
    int bad   = 0;

    // Simple FIFO stand-ins: storage written by the stimulus, popped on rd_en.
    logic [WIDTH-1:0] val_mem[64];
    logic [WIDTH-1:0] ival_mem[64];
    int val_wr = 0, val_rd = 0, ival_wr = 0, ival_rd = 0;
    int vpops = 0, ipops = 0, overlap = 0;

    // Reference contents, as the specification sees the FIFOs.
    logic [WIDTH-1:0] val_ref[$];
    logic [WIDTH-1:0] ival_ref[$];

    assign val_empty     = (val_wr == val_rd);
    assign ival_empty    = (ival_wr == ival_rd);
    assign val_full      = (val_wr - val_rd) >= FULL_LVL;
    assign ival_full     = (ival_wr - ival_rd) >= FULL_LVL;
    assign val_fifo_ctr  = DEPTH'(val_wr - val_rd);
    assign ival_fifo_ctr = DEPTH'(ival_wr - ival_rd);

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (val_rd_en) begin
            val_dout <= val_mem[val_rd[5:0]];
            val_rd   <= val_rd + 1;
            vpops    <= vpops + 1;
        end
        if (ival_rd_en) begin
            ival_dout <= ival_mem[ival_rd[5:0]];
            ival_rd   <= ival_rd + 1;
            ipops     <= ipops + 1;
        end
        if (val_rd_en && ival_rd_en) overlap <= overlap + 1;
    end

    axil_sorter_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .ARADDR        (ARADDR),
        .ARVALID       (ARVALID),
        .ARREADY       (ARREADY),
        .RDATA         (RDATA),
        .RRESP         (RRESP),
        .RVALID        (RVALID),
        .RREADY        (RREADY),
        .val_rd_en     (val_rd_en),
        .ival_rd_en    (ival_rd_en),
        .val_dout      (val_dout),
        .ival_dout     (ival_dout),
        .val_empty     (val_empty),
        .val_full      (val_full),
        .ival_empty    (ival_empty),
        .ival_full     (ival_full),
        .val_fifo_ctr  (val_fifo_ctr),
        .ival_fifo_ctr (ival_fifo_ctr)
    );

    typedef struct {
        logic [31:0] addr;
        int          stall;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        int          exp_lat;
        int          exp_vp;
        int          exp_ip;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_val(input logic [WIDTH-1:0] d, input bit to_ref);
        val_mem[val_wr[5:0]] = d;
        val_wr++;
        if (to_ref) val_ref.push_back(d);
    endtask

    task automatic push_ival(input logic [WIDTH-1:0] d, input bit to_ref);
        ival_mem[ival_wr[5:0]] = d;
        ival_wr++;
        if (to_ref) ival_ref.push_back(d);
    endtask

    // One complete read: issue, measure latency, check response, hold-off, release.
    task automatic txn(input vec_t v, input string tag);
        int v0 = vpops;
        int i0 = ipops;
        int cyc;
        RREADY  = (v.stall == 0);
        ARADDR  = v.addr;
        ARVALID = 1'b1;
        check({tag, ".arready"}, 32'(ARREADY), 32'd1);
        @(posedge clk); #1;
        ARVALID = 1'b0;
        cyc = 1;
        while (!RVALID && cyc < 8) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, ".latency"}, 32'(cyc), 32'(v.exp_lat));
        check({tag, ".rdata"}, RDATA, v.exp_data);
        check({tag, ".rresp"}, 32'(RRESP), 32'(v.exp_resp));
        for (int s = 0; s < v.stall; s++) begin
            @(posedge clk); #1;
            check({tag, ".hold_rvalid"}, 32'(RVALID), 32'd1);
            check({tag, ".hold_rdata"}, RDATA, v.exp_data);
            check({tag, ".hold_rresp"}, 32'(RRESP), 32'(v.exp_resp));
            check({tag, ".hold_arready"}, 32'(ARREADY), 32'd0);
        end
        RREADY = 1'b1;
        @(posedge clk); #1;
        check({tag, ".rvalid_drop"}, 32'(RVALID), 32'd0);
        check({tag, ".arready_back"}, 32'(ARREADY), 32'd1);
        check({tag, ".val_pops"}, 32'(vpops - v0), 32'(v.exp_vp));
        check({tag, ".ival_pops"}, 32'(ipops - i0), 32'(v.exp_ip));
    endtask

    // Expected outcome derived from the address map and the reference queues.
    task automatic model_txn(input logic [31:0] addr, input int stall, input string tag);
        vec_t v;
        v.addr = addr; v.stall = stall;
        v.exp_data = 32'h0; v.exp_resp = 2'b00; v.exp_lat = 1; v.exp_vp = 0; v.exp_ip = 0;
        if (addr == 32'h0) begin
            if (val_ref.size() == 0) v.exp_resp = 2'b10;
            else begin
                v.exp_data = 32'(val_ref.pop_front());
                v.exp_lat = 2; v.exp_vp = 1;
            end
        end else if (addr == 32'h4) begin
            if (ival_ref.size() == 0) v.exp_resp = 2'b10;
            else begin
                v.exp_data = 32'(ival_ref.pop_front());
                v.exp_lat = 2; v.exp_ip = 1;
            end
        end else if (addr == 32'h8) begin
            v.exp_data = (ival_ref.size() >= FULL_LVL ? 32'h8000_0000 : 32'h0)
                       + (val_ref.size()  >= FULL_LVL ? 32'h4000_0000 : 32'h0)
                       + (ival_ref.size() == 0        ? 32'h2000_0000 : 32'h0)
                       + (val_ref.size()  == 0        ? 32'h1000_0000 : 32'h0)
                       + 32'(ival_ref.size()) * 32'h1_0000
                       + 32'(val_ref.size());
        end else begin
            v.exp_resp = 2'b11;
        end
        txn(v, tag);
    endtask

    vec_t vecs[10];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        int v0;
        logic [31:0] a;

        vecs[0] = '{32'h0000_0008, 0, 32'h0001_0002, 2'b00, 1, 0, 0};
        vecs[1] = '{32'h0000_0000, 0, 32'h0000_00A5, 2'b00, 2, 1, 0};
        vecs[2] = '{32'h0000_0000, 1, 32'h0000_1234, 2'b00, 2, 1, 0};
        vecs[3] = '{32'h0000_0004, 0, 32'h0000_0077, 2'b00, 2, 0, 1};
        vecs[4] = '{32'h0000_0004, 0, 32'h0000_0000, 2'b10, 1, 0, 0};
        vecs[5] = '{32'h0000_0000, 0, 32'h0000_0000, 2'b10, 1, 0, 0};
        vecs[6] = '{32'h0000_000C, 0, 32'h0000_0000, 2'b11, 1, 0, 0};
        vecs[7] = '{32'h0000_0008, 0, 32'h3000_0000, 2'b00, 1, 0, 0};
        vecs[8] = '{32'h0000_0100, 0, 32'h0000_0000, 2'b11, 1, 0, 0};
        vecs[9] = '{32'h8000_0008, 2, 32'h0000_0000, 2'b11, 1, 0, 0};

        // Reset with a pending pop request: nothing may be accepted or popped.
        push_val(16'h00A5, 1'b0);
        push_val(16'h1234, 1'b0);
        push_ival(16'h0077, 1'b0);
        ARADDR = 32'h0; ARVALID = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst.arready", 32'(ARREADY), 32'd0);
        check("rst.rvalid", 32'(RVALID), 32'd0);
        check("rst.rdata", RDATA, 32'h0);
        check("rst.rresp", 32'(RRESP), 32'd0);
        check("rst.val_rd_en", 32'(val_rd_en), 32'd0);
        check("rst.ival_rd_en", 32'(ival_rd_en), 32'd0);
        check("rst.pops", 32'(vpops + ipops), 32'd0);
        ARVALID = 1'b0;
        rst = 1'b0;
        #1;
        check("rst.arready_release", 32'(ARREADY), 32'd1);

        foreach (vecs[i]) txn(vecs[i], $sformatf("vec%0d", i));

        // Long RREADY hold-off on a successful pop.
        push_val(16'h00C3, 1'b1);
        model_txn(32'h0, 4, "stall4");

        // Reset during FETCH: the accepted pop stands, no further strobe.
        push_val(16'h5A5A, 1'b1);
        ARADDR = 32'h0; ARVALID = 1'b1;
        @(posedge clk); #1;
        ARVALID = 1'b0;
        rst = 1'b1;
        v0 = vpops;
        @(posedge clk); #1;
        check("rst_fetch.rvalid", 32'(RVALID), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("rst_fetch.no_pop", 32'(vpops - v0), 32'd0);
        check("rst_fetch.arready", 32'(ARREADY), 32'd1);
        void'(val_ref.pop_front());

        // Reset during RESP: response is dropped, port returns to idle.
        push_ival(16'h0F0F, 1'b1);
        RREADY = 1'b0;
        ARADDR = 32'h4; ARVALID = 1'b1;
        @(posedge clk); #1;
        ARVALID = 1'b0;
        cyc = 0;
        while (!RVALID && cyc < 8) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("rst_resp.reached", 32'(RVALID), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_resp.rvalid", 32'(RVALID), 32'd0);
        check("rst_resp.arready_in_rst", 32'(ARREADY), 32'd0);
        rst = 1'b0;
        RREADY = 1'b1;
        @(posedge clk); #1;
        check("rst_resp.arready", 32'(ARREADY), 32'd1);
        check("rst_resp.rvalid_after", 32'(RVALID), 32'd0);
        void'(ival_ref.pop_front());
        model_txn(32'h8, 0, "post_rst_status");

        // Randomized traffic against the reference queues.
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 2) != 0 && val_ref.size() < 12)  push_val(16'($urandom), 1'b1);
            if ($urandom_range(0, 2) != 0 && ival_ref.size() < 12) push_ival(16'($urandom), 1'b1);
            case ($urandom_range(0, 6))
                0, 1:    a = 32'h0;
                2, 3:    a = 32'h4;
                4:       a = 32'h8;
                5:       a = 32'hC;
                default: a = $urandom;
            endcase
            model_txn(a, $urandom_range(0, 2), $sformatf("rnd%0d", n));
        end

        check("rd_en_overlap", 32'(overlap), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
